// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants and projectile stage types.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;
    localparam int FRAC       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLY    = 2'd1,
        LANDED = 2'd2
    } proj_state_t;

endpackage

// File: rtl/projectile_cat_ctl.sv
// Ballistic trajectory controller for the cat's projectile: launch, per-frame
// integration, landing hold and off-screen detection.
module projectile_cat_ctl #(
    parameter int START_X     = 40,
    parameter int START_Y     = 100,
    parameter int GROUND_Y    = 20,
    parameter int GRAVITY     = 8,
    parameter int FRAC        = vga_pkg::FRAC,
    parameter int DIAMETER    = 30,
    parameter int HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        throw_start,
    input  logic [6:0]  power,
    output logic        enable,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        busy,
    output logic        done,
    output logic        miss
);
    import vga_pkg::*;

    localparam int PW = 12 + FRAC;
    localparam int AW = PW + 2;
    localparam int HW = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;

    localparam logic signed [AW-1:0] X_LIMIT_C = signed'(AW'((HOR_PIXELS + DIAMETER) << FRAC));
    localparam logic signed [AW-1:0] GROUND_C  = signed'(AW'(GROUND_Y << FRAC));
    localparam logic [PW-1:0]        START_PX  = PW'(START_X << FRAC);
    localparam logic [PW-1:0]        START_PY  = PW'(START_Y << FRAC);
    localparam logic [PW-1:0]        GROUND_PY = PW'(GROUND_Y << FRAC);
    localparam logic [HW-1:0]        HOLD_LAST = HW'(HOLD_FRAMES - 1);
    localparam logic [11:0]          GRAV_C    = 12'(GRAVITY);

    proj_state_t        state_r;
    logic [PW-1:0]      px_r;
    logic [PW-1:0]      py_r;
    logic [9:0]         vx_r;
    logic signed [11:0] vy_r;
    logic [HW-1:0]      hold_cnt_r;
    logic               enable_r;
    logic               busy_r;
    logic               done_r;
    logic               miss_r;

    logic [9:0]         v0_s;
    logic signed [AW-1:0] nx_s;
    logic signed [AW-1:0] ny_s;
    logic [PW-1:0]      ny_sat_s;

    // Candidate next position from the current velocity, with upward saturation
    always_comb begin
        v0_s = {1'b0, power, 2'b00};
        nx_s = $signed({2'b00, px_r}) + $signed({{(AW-10){1'b0}}, vx_r});
        ny_s = $signed({2'b00, py_r}) + $signed({{(AW-12){vy_r[11]}}, vy_r});
        if (ny_s[AW-1:PW] != 2'b00) begin
            ny_sat_s = {PW{1'b1}};
        end else begin
            ny_sat_s = ny_s[PW-1:0];
        end
    end

    // Throw state machine; all outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            px_r       <= '0;
            py_r       <= '0;
            vx_r       <= 10'd0;
            vy_r       <= 12'sd0;
            hold_cnt_r <= '0;
            enable_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            miss_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (throw_start) begin
                        px_r     <= START_PX;
                        py_r     <= START_PY;
                        vx_r     <= v0_s;
                        vy_r     <= $signed({2'b00, v0_s});
                        miss_r   <= 1'b0;
                        enable_r <= 1'b1;
                        busy_r   <= 1'b1;
                        state_r  <= FLY;
                    end
                end
                FLY: begin
                    if (frame_tick) begin
                        // Leaving the screen wins over landing on the same frame
                        if (nx_s >= X_LIMIT_C) begin
                            state_r  <= IDLE;
                            enable_r <= 1'b0;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            miss_r   <= 1'b1;
                        end else if (ny_s <= GROUND_C) begin
                            px_r       <= nx_s[PW-1:0];
                            py_r       <= GROUND_PY;
                            hold_cnt_r <= '0;
                            state_r    <= LANDED;
                        end else begin
                            px_r <= nx_s[PW-1:0];
                            py_r <= ny_sat_s;
                            vy_r <= vy_r - $signed(GRAV_C);
                        end
                    end
                end
                LANDED: begin
                    if (frame_tick) begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            state_r  <= IDLE;
                            enable_r <= 1'b0;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HW'(1);
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign enable = enable_r;
    assign busy   = busy_r;
    assign done   = done_r;
    assign miss   = miss_r;
    assign x_pos  = px_r[FRAC+11:FRAC];
    assign y_pos  = py_r[FRAC+11:FRAC];

endmodule

// File: tb/tb_projectile_cat_ctl.sv
// Directed bench for projectile_cat_ctl: default instance plus one launched
// near the right edge to exercise the off-screen exit.
module tb_projectile_cat_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        throw_start = 1'b0;
    logic [6:0]  power = 7'd0;

    logic        enable, busy, done, miss;
    logic [11:0] x_pos, y_pos;
    logic        f_enable, f_busy, f_done, f_miss;
    logic [11:0] f_x_pos, f_y_pos;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    projectile_cat_ctl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .throw_start(throw_start),
        .power(power), .enable(enable), .x_pos(x_pos), .y_pos(y_pos),
        .busy(busy), .done(done), .miss(miss)
    );

    projectile_cat_ctl #(.START_X(600)) dut_far (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .throw_start(throw_start),
        .power(power), .enable(f_enable), .x_pos(f_x_pos), .y_pos(f_y_pos),
        .busy(f_busy), .done(f_done), .miss(f_miss)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic launch(input logic [6:0] p);
        power = p;
        throw_start = 1'b1;
        step();
        throw_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({enable, busy, done, miss} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {enable, busy, done, miss}); end
        total++; if ({x_pos, y_pos} !== 24'd0) begin bad++; $display("FAIL reset_pos: got %0d/%0d want 0/0", x_pos, y_pos); end
        launch(7'd16);
        repeat (3) tick();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({enable, busy, done} !== 3'b000) begin bad++; $display("FAIL midflight_rst_flags: got %b want 000", {enable, busy, done}); end
        total++; if ({x_pos, y_pos} !== 24'd0) begin bad++; $display("FAIL midflight_rst_pos: got %0d/%0d want 0/0", x_pos, y_pos); end
    endtask

    task automatic test_launch();
        do_reset();
        launch(7'd16);
        total++; if ({enable, busy} !== 2'b11) begin bad++; $display("FAIL launch_flags: got %b want 11", {enable, busy}); end
        total++; if (x_pos !== 12'd40 || y_pos !== 12'd100) begin bad++; $display("FAIL launch_pos: got %0d/%0d want 40/100", x_pos, y_pos); end
        step();
        tick();
        total++; if (x_pos !== 12'd44 || y_pos !== 12'd104) begin bad++; $display("FAIL tick1_pos: got %0d/%0d want 44/104", x_pos, y_pos); end
        step();
        tick();
        total++; if (x_pos !== 12'd48 || y_pos !== 12'd107) begin bad++; $display("FAIL tick2_pos: got %0d/%0d want 48/107", x_pos, y_pos); end
    endtask

    task automatic test_ignored();
        do_reset();
        frame_tick = 1'b1;
        launch(7'd16);
        frame_tick = 1'b0;
        total++; if (x_pos !== 12'd40 || y_pos !== 12'd100) begin bad++; $display("FAIL launch_with_tick: got %0d/%0d want 40/100", x_pos, y_pos); end
        step();
        total++; if (x_pos !== 12'd40 || y_pos !== 12'd100) begin bad++; $display("FAIL idle_after_launch: got %0d/%0d want 40/100", x_pos, y_pos); end
        tick();
        launch(7'd127);
        total++; if (x_pos !== 12'd44 || y_pos !== 12'd104) begin bad++; $display("FAIL throw_in_fly: got %0d/%0d want 44/104", x_pos, y_pos); end
        tick();
        total++; if (x_pos !== 12'd48 || y_pos !== 12'd107) begin bad++; $display("FAIL fly_after_ignored: got %0d/%0d want 48/107", x_pos, y_pos); end
    endtask

    task automatic test_landing();
        int prev;
        int exp_y;
        do_reset();
        launch(7'd0);
        prev = 100;
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_y = (1600 - 4 * k * (k - 1)) / 16;
            total++; if (y_pos !== 12'(exp_y) || int'(y_pos) > prev) begin bad++; $display("FAIL fall_tick%0d: got y=%0d want %0d", k, y_pos, exp_y); end
            prev = int'(y_pos);
        end
        tick();
        total++; if (x_pos !== 12'd40 || y_pos !== 12'd20 || enable !== 1'b1) begin bad++; $display("FAIL land_pos: got %0d/%0d en=%b want 40/20 en=1", x_pos, y_pos, enable); end
        for (int i = 1; i <= 29; i++) begin
            tick();
            total++; if ({enable, done} !== 2'b10) begin bad++; $display("FAIL hold_tick%0d: got en,done=%b want 10", i, {enable, done}); end
        end
        tick();
        total++; if ({done, miss, enable, busy} !== 4'b1000) begin bad++; $display("FAIL land_done: got done,miss,en,busy=%b want 1000", {done, miss, enable, busy}); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL land_done_width: got %b want 0", done); end
    endtask

    task automatic test_offscreen();
        do_reset();
        launch(7'd127);
        total++; if (f_x_pos !== 12'd600 || f_y_pos !== 12'd100) begin bad++; $display("FAIL far_launch: got %0d/%0d want 600/100", f_x_pos, f_y_pos); end
        repeat (7) tick();
        total++; if (f_x_pos !== 12'd822 || f_y_pos !== 12'd311 || f_enable !== 1'b1) begin bad++; $display("FAIL far_tick7: got %0d/%0d en=%b want 822/311 en=1", f_x_pos, f_y_pos, f_enable); end
        tick();
        total++; if ({f_done, f_miss, f_enable, f_busy} !== 4'b1100) begin bad++; $display("FAIL far_exit: got done,miss,en,busy=%b want 1100", {f_done, f_miss, f_enable, f_busy}); end
    endtask

    task automatic test_back_to_back();
        launch(7'd16);
        total++; if ({f_busy, f_enable, f_miss, f_done} !== 4'b1100) begin bad++; $display("FAIL b2b_flags: got busy,en,miss,done=%b want 1100", {f_busy, f_enable, f_miss, f_done}); end
        total++; if (f_x_pos !== 12'd600 || f_y_pos !== 12'd100) begin bad++; $display("FAIL b2b_pos: got %0d/%0d want 600/100", f_x_pos, f_y_pos); end
        tick();
        total++; if (f_x_pos !== 12'd604 || f_y_pos !== 12'd104) begin bad++; $display("FAIL b2b_tick1: got %0d/%0d want 604/104", f_x_pos, f_y_pos); end
    endtask

    // Guard against a stalled run
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_launch();
        test_ignored();
        test_landing();
        test_offscreen();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
